// File: rtl/s2p_pkg.sv
// Shared FSM state encoding and sizing helpers for the serial-to-parallel framer.
package s2p_pkg;

    localparam int unsigned S2P_MAX_WIDTH = 32;

    typedef logic [0:0] s2p_state_t;
    localparam s2p_state_t IDLE  = 1'b0;
    localparam s2p_state_t SHIFT = 1'b1;

    function automatic int unsigned s2p_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/s2p_shift_reg.sv
// Enabled serial-in shift register; MSB_FIRST selects the end new bits enter from.
module s2p_shift_reg
    import s2p_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_sin,
    output logic [DATA_WIDTH-1:0] o_par
);

    logic [DATA_WIDTH-1:0] r_sr;
    logic [DATA_WIDTH+1:0] w_ext;
    logic [DATA_WIDTH-1:0] w_next;

    // Padding the serial bit on both sides keeps the slices legal for a 1-bit register.
    assign w_ext  = {i_sin, r_sr, i_sin};
    assign w_next = MSB_FIRST ? w_ext[DATA_WIDTH-1:0] : w_ext[DATA_WIDTH+1:2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr <= w_next;
        end
    end

    assign o_par = r_sr;

endmodule

// File: rtl/s2p_framer.sv
// Serial-to-parallel framer with done/outReady handoff and overrun pulse.
// Optional even-parity trailer bit enabled by defining S2P_FRAMER_PARITY_EN.
module s2p_framer
    import s2p_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic                  clk1x,
    input  logic                  reset,
    input  logic                  dataSIN,
    input  logic                  receiveFlag,
    input  logic                  outReady,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  done,
    output logic                  busy,
    output logic                  overrun,
    output logic                  parityErr
);

`ifdef S2P_FRAMER_PARITY_EN
    localparam int unsigned N = DATA_WIDTH + 1;
`else
    localparam int unsigned N = DATA_WIDTH;
`endif
    localparam int unsigned CW = s2p_cnt_width(N);

    s2p_state_t            r_state, w_state_d;
    logic [CW-1:0]         r_cnt, w_cnt_d;
    logic [N-2:0]          w_par;
    logic [N-1:0]          w_full;
    logic [DATA_WIDTH-1:0] w_payload;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_shift_en, w_last, w_load, w_done_d;
    logic                  r_done, r_ovr;

    // The register holds bits 0..N-2; the last bit is taken straight from dataSIN.
    assign w_shift_en = (r_state == SHIFT) || receiveFlag;

    s2p_shift_reg #(
        .DATA_WIDTH (N - 1),
        .MSB_FIRST  (MSB_FIRST)
    ) u_shift_reg (
        .i_clk   (clk1x),
        .i_rst_n (reset),
        .i_en    (w_shift_en),
        .i_sin   (dataSIN),
        .o_par   (w_par)
    );

    assign w_full    = MSB_FIRST ? {w_par, dataSIN} : {dataSIN, w_par};
    assign w_payload = MSB_FIRST ? w_full[N-1 -: DATA_WIDTH] : w_full[DATA_WIDTH-1:0];

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_last    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (receiveFlag) begin
                    w_state_d = SHIFT;
                    w_cnt_d   = CW'(1);
                end
            end
            SHIFT: begin
                if (receiveFlag) begin
                    w_cnt_d = CW'(1);
                end else if (r_cnt == CW'(N - 1)) begin
                    w_last    = 1'b1;
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    assign w_load   = w_last && (!r_done || outReady);
    assign w_done_d = w_load || (r_done && !outReady);

    always_ff @(posedge clk1x or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_done  <= w_done_d;
            r_ovr   <= w_last && !w_load;
            if (w_load) begin
                r_data <= w_payload;
            end
        end
    end

`ifdef S2P_FRAMER_PARITY_EN
    logic r_perr;

    always_ff @(posedge clk1x or negedge reset) begin
        if (!reset) begin
            r_perr <= 1'b0;
        end else if (w_load) begin
            r_perr <= ^w_full;
        end
    end

    assign parityErr = r_perr;
`else
    assign parityErr = 1'b0;
`endif

    assign dataOut = r_data;
    assign done    = r_done;
    assign busy    = (r_state == SHIFT);
    assign overrun = r_ovr;

endmodule
